aes_inv_subshift_ark: RTL and testbench

- Iterative decryption-round front half: InvShiftRows, then InvSubBytes, then AddRoundKey on one 128-bit AES state.
- Its 128-bit result is the stateIn operand of InverseMixColumns, which sits directly downstream.
- Processes one 32-bit column per cycle with 4 inverse S-box instances.
- Uses valid/ready handshakes on both sides so the round controller can stall it.

---
 rtl/aes_inv_subshift_ark.sv | 115 +++++++++++
 tb/tb_aes_inv_subshift_ark.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_inv_subshift_ark.sv
// AES decryption round front half: InvShiftRows, InvSubBytes, AddRoundKey.
// Ports: clk/rst_n, in_valid/in_ready/state_in/round_key, out_valid/out_ready/state_out.
module aes_inv_subshift_ark (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } st_t;

  st_t          st_q;
  st_t          st_d;
  logic [1:0]   col_q;
  logic [127:0] in_q;
  logic [127:0] key_q;
  logic [127:0] out_q;
  logic [31:0]  col_res;

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // x^254 by repeated squaring; maps 0 to 0.
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] s;
    r = 8'h01;
    s = a;
    for (int i = 1; i < 8; i++) begin
      s = gf_mul(s, s);
      r = gf_mul(r, s);
    end
    return r;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    logic [7:0] t;
    t = {x[6:0], x[7]}
      ^ {x[4:0], x[7:5]}
      ^ {x[1:0], x[7:2]}
      ^ 8'h05;
    return gf_inv(t);
  endfunction

  // Row r of the output column reads input column (col - r) mod 4.
  always_comb begin
    col_res = '0;
    for (int r = 0; r < 4; r++) begin
      logic [1:0] sc;
      int         si;
      int         di;
      sc = col_q - 2'(r);
      si = r + 4 * int'(sc);
      di = r + 4 * int'(col_q);
      col_res[31-8*r -: 8] = inv_sbox(in_q[127-8*si -: 8])
                           ^ key_q[127-8*di -: 8];
    end
  end

  always_comb begin
    st_d = st_q;
    unique case (st_q)
      IDLE:    if (in_valid) st_d = BUSY;
      BUSY:    if (col_q == 2'd3) st_d = DONE;
      DONE:    if (out_ready) st_d = IDLE;
      default: st_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st_q  <= IDLE;
      col_q <= 2'd0;
      out_q <= '0;
    end else begin
      st_q <= st_d;
      if (st_q == IDLE && in_valid) begin
        in_q  <= state_in;
        key_q <= round_key;
        out_q <= '0;
        col_q <= 2'd0;
      end
      if (st_q == BUSY) begin
        out_q[127-32*int'(col_q) -: 32] <= col_res;
        col_q <= col_q + 2'd1;
      end
    end
  end

  assign in_ready  = (st_q == IDLE);
  assign out_valid = (st_q == DONE);
  assign state_out = out_q;

endmodule

// File: tb/tb_aes_inv_subshift_ark.sv
// Scoreboard bench for aes_inv_subshift_ark.
// Reference inverse S-box is built by inverting the forward FIPS-197 S-box.
module tb_aes_inv_subshift_ark;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] state_out;

  int           cyc = 0;
  int           vectors = 0;
  int           errs = 0;
  int           acc_cyc = 0;
  int           prev_acc = 0;
  logic [127:0] sbq[$];
  logic [7:0]   isb[256];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  aes_inv_subshift_ark dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .state_in  (state_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .state_out (state_out)
  );

  function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] v;
    v = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gm(a, 8'(b)) == 8'h01) v = 8'(b);
    return v;
  endfunction

  function automatic logic [7:0] rl(input logic [7:0] x, input int n);
    logic [15:0] t;
    t = {x, x} << n;
    return t[15:8];
  endfunction

  function automatic logic [7:0] fsb(input logic [7:0] x);
    logic [7:0] b;
    b = ginv(x);
    return b ^ rl(b, 1) ^ rl(b, 2) ^ rl(b, 3) ^ rl(b, 4) ^ 8'h63;
  endfunction

  function automatic logic [127:0] model(input logic [127:0] s, input logic [127:0] k);
    logic [127:0] o;
    int si;
    int di;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        si = r + 4 * ((c - r + 4) % 4);
        di = r + 4 * c;
        o[127-8*di -: 8] = isb[s[127-8*si -: 8]] ^ k[127-8*di -: 8];
      end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [127:0] s, input logic [127:0] k);
    int n;
    n = 0;
    in_valid  = 1'b1;
    state_in  = s;
    round_key = k;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept", 128'(in_ready), 128'd1);
    @(negedge clk);
    prev_acc = acc_cyc;
    acc_cyc  = cyc;
    sbq.push_back(model(s, k));
    in_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input int lat, input logic keep);
    int n;
    logic [127:0] e;
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_valid"}, 128'(out_valid), 128'd1);
    if (lat >= 0) chk({tag, "_lat"}, 128'(cyc - acc_cyc), 128'(lat));
    e = (sbq.size() > 0) ? sbq.pop_front() : 128'hx;
    chk(tag, state_out, e);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = keep;
  endtask

  initial begin
    logic [127:0] s;
    logic [127:0] k;
    logic [127:0] hb;
    int n;

    for (int x = 0; x < 256; x++) isb[fsb(8'(x))] = 8'(x);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    state_in  = '0;
    round_key = '0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_state_out", state_out, 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    send('0, '0);
    recv("zero", 4, 1'b0);
    chk("zero_const", model('0, '0), {16{8'h52}});

    send({16{8'h63}}, '1);
    recv("ones", 4, 1'b0);

    s = 128'h637c777bf26b6fc53001672bfed7ab76;
    send(s, '0);
    vectors++;
    assert (sbq[0] === 128'h000d0a0704010e0b0805020f0c090603) else begin
      errs++;
      $error("FAIL shift_model observed=%h expected=%h", sbq[0],
             128'h000d0a0704010e0b0805020f0c090603);
    end
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("shift", state_out, 128'h000d0a0704010e0b0805020f0c090603);
    sbq.pop_front();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    s = {$urandom, $urandom, $urandom, $urandom};
    k = {$urandom, $urandom, $urandom, $urandom};
    send(s, k);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    hb        = {$urandom, $urandom, $urandom, $urandom};
    in_valid  = 1'b1;
    state_in  = hb;
    round_key = k;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("hold_valid", 128'(out_valid), 128'd1);
      chk("hold_data", state_out, sbq[0]);
      chk("hold_in_ready", 128'(in_ready), 128'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    sbq.pop_front();
    chk("hold_release_valid", 128'(out_valid), 128'd0);
    chk("hold_release_ready", 128'(in_ready), 128'd1);
    @(negedge clk);
    chk("hold_b_taken", 128'(in_ready), 128'd0);
    acc_cyc = cyc;
    sbq.push_back(model(hb, k));
    in_valid = 1'b0;
    recv("hold_b", 4, 1'b0);

    send({$urandom, $urandom, $urandom, $urandom}, '1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    void'(sbq.pop_back());
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_state_out", state_out, 128'd0);
    repeat (4) begin
      @(negedge clk);
      chk("mid_rst_no_out", 128'(out_valid), 128'd0);
    end
    send('0, '0);
    recv("post_rst_zero", 4, 1'b0);

    out_ready = 1'b1;
    send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    recv("b2b", 4, 1'b1);
    for (int i = 0; i < 3; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      chk("b2b_gap", 128'(acc_cyc - prev_acc - 1), 128'd5);
      recv("b2b", 4, 1'b1);
    end

    for (int i = 0; i < 1000; i++) begin
      send({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
      recv("rand", -1, 1'b1);
    end
    out_ready = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
